// File: rtl/serial_adder.sv
// Digit-serial adder: DIGIT bits per clock through a ripple chain, carry held in a
// flip-flop between cycles, framed by a start/busy/done handshake.
module serial_adder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             overflow_o
);

    localparam int unsigned N    = WIDTH / DIGIT;
    localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

    if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_param
        $error("serial_adder: need 1 <= DIGIT <= WIDTH and WIDTH divisible by DIGIT");
    end

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q;
    logic [WIDTH-1:0]  a_q, b_q, psum_q, sum_q;
    logic              carry_q, busy_q, done_q, cout_q, overflow_q;
    logic [CntW-1:0]   cnt_q;

    logic [DIGIT-1:0]  digit_sum;
    logic              chain_cout, chain_msb_cin;
    logic [WIDTH-1:0]  psum_d;

    // Ripple chain over the low DIGIT operand bits; also exposes the carry into the top cell.
    always_comb begin
        logic c;
        digit_sum     = '0;
        chain_msb_cin = 1'b0;
        c             = carry_q;
        for (int i = 0; i < int'(DIGIT); i++) begin
            digit_sum[i] = a_q[i] ^ b_q[i] ^ c;
            if (i == int'(DIGIT) - 1) begin
                chain_msb_cin = c;
            end
            c = (a_q[i] & b_q[i]) | (c & (a_q[i] ^ b_q[i]));
        end
        chain_cout = c;
    end

    // New digit enters at the top; after N digits the LSB digit has reached bit 0.
    always_comb begin
        psum_d = (psum_q >> DIGIT) | (WIDTH'(digit_sum) << (WIDTH - DIGIT));
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            a_q        <= '0;
            b_q        <= '0;
            psum_q     <= '0;
            carry_q    <= 1'b0;
            cnt_q      <= '0;
            sum_q      <= '0;
            cout_q     <= 1'b0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        a_q     <= a_i;
                        b_q     <= b_i;
                        carry_q <= cin_i;
                        psum_q  <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= StRun;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StRun: begin
                    a_q     <= a_q >> DIGIT;
                    b_q     <= b_q >> DIGIT;
                    psum_q  <= psum_d;
                    carry_q <= chain_cout;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == LastCnt) begin
                        sum_q      <= psum_d;
                        cout_q     <= chain_cout;
                        overflow_q <= chain_msb_cin ^ chain_cout;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        state_q    <= StDone;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign sum_o      = sum_q;
    assign cout_o     = cout_q;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: three instances (16/4, 4/1, 16/16) with a scoreboard queue each.
module tb_serial_adder;

    typedef struct packed {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        int unsigned cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int unsigned cyc = 0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Main instance: WIDTH=16, DIGIT=4 (N=4)
    logic        m_start, m_cin, m_busy, m_done, m_cout, m_ovf;
    logic [15:0] m_a, m_b, m_sum;
    // Narrow instance: WIDTH=4, DIGIT=1 (N=4)
    logic        s_start, s_cin, s_busy, s_done, s_cout, s_ovf;
    logic [3:0]  s_a, s_b, s_sum;
    // Full-width instance: WIDTH=16, DIGIT=16 (N=1)
    logic        f_start, f_cin, f_busy, f_done, f_cout, f_ovf;
    logic [15:0] f_a, f_b, f_sum;

    exp_t q_m[$];
    exp_t q_s[$];
    exp_t q_f[$];
    exp_t e_m, e_s, e_f;

    serial_adder #(.WIDTH(16), .DIGIT(4)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(m_start), .a_i(m_a), .b_i(m_b), .cin_i(m_cin),
        .busy_o(m_busy), .done_o(m_done), .sum_o(m_sum), .cout_o(m_cout), .overflow_o(m_ovf)
    );

    serial_adder #(.WIDTH(4), .DIGIT(1)) u_w4 (
        .clk(clk), .rst_n(rst_n), .start_i(s_start), .a_i(s_a), .b_i(s_b), .cin_i(s_cin),
        .busy_o(s_busy), .done_o(s_done), .sum_o(s_sum), .cout_o(s_cout), .overflow_o(s_ovf)
    );

    serial_adder #(.WIDTH(16), .DIGIT(16)) u_full (
        .clk(clk), .rst_n(rst_n), .start_i(f_start), .a_i(f_a), .b_i(f_b), .cin_i(f_cin),
        .busy_o(f_busy), .done_o(f_done), .sum_o(f_sum), .cout_o(f_cout), .overflow_o(f_ovf)
    );

    // Reference for 16-bit operands; overflow from operand/result sign bits.
    function automatic exp_t model16(input logic [15:0] a, input logic [15:0] b, input logic c,
                                     input int unsigned lat);
        logic [16:0] f;
        exp_t r;
        f     = {1'b0, a} + {1'b0, b} + {16'd0, c};
        r.sum = f[15:0];
        r.cout = f[16];
        r.ovf = (a[15] == b[15]) && (f[15] != a[15]);
        r.cyc = cyc + 1 + lat;
        return r;
    endfunction

    function automatic exp_t model4(input logic [3:0] a, input logic [3:0] b, input logic c);
        logic [4:0] f;
        exp_t r;
        f      = {1'b0, a} + {1'b0, b} + {4'd0, c};
        r.sum  = {12'd0, f[3:0]};
        r.cout = f[4];
        r.ovf  = (a[3] == b[3]) && (f[3] != a[3]);
        r.cyc  = cyc + 1 + 4;
        return r;
    endfunction

    // Scoreboard monitors: compare result and latency on every done pulse.
    always @(negedge clk) begin
        if (m_done) begin
            checks++;
            if (q_m.size() == 0) begin
                errors++;
                $display("FAIL m_unexpected_done: got done=1 sum=%h, expected no done", m_sum);
            end else begin
                e_m = q_m.pop_front();
                if ({m_sum, m_cout, m_ovf} !== {e_m.sum, e_m.cout, e_m.ovf}) begin
                    errors++;
                    $display("FAIL m_result: got sum=%h cout=%b ovf=%b, expected sum=%h cout=%b ovf=%b",
                             m_sum, m_cout, m_ovf, e_m.sum, e_m.cout, e_m.ovf);
                end
                checks++;
                if (cyc !== e_m.cyc) begin
                    errors++;
                    $display("FAIL m_latency: done at cycle %0d, expected %0d", cyc, e_m.cyc);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (s_done) begin
            checks++;
            if (q_s.size() == 0) begin
                errors++;
                $display("FAIL s_unexpected_done: got done=1 sum=%h, expected no done", s_sum);
            end else begin
                e_s = q_s.pop_front();
                if ({12'd0, s_sum, s_cout, s_ovf} !== {e_s.sum, e_s.cout, e_s.ovf}) begin
                    errors++;
                    $display("FAIL s_result: got sum=%h cout=%b ovf=%b, expected sum=%h cout=%b ovf=%b",
                             s_sum, s_cout, s_ovf, e_s.sum[3:0], e_s.cout, e_s.ovf);
                end
                checks++;
                if (cyc !== e_s.cyc) begin
                    errors++;
                    $display("FAIL s_latency: done at cycle %0d, expected %0d", cyc, e_s.cyc);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (f_done) begin
            checks++;
            if (q_f.size() == 0) begin
                errors++;
                $display("FAIL f_unexpected_done: got done=1 sum=%h, expected no done", f_sum);
            end else begin
                e_f = q_f.pop_front();
                if ({f_sum, f_cout, f_ovf} !== {e_f.sum, e_f.cout, e_f.ovf}) begin
                    errors++;
                    $display("FAIL f_result: got sum=%h cout=%b ovf=%b, expected sum=%h cout=%b ovf=%b",
                             f_sum, f_cout, f_ovf, e_f.sum, e_f.cout, e_f.ovf);
                end
                checks++;
                if (cyc !== e_f.cyc) begin
                    errors++;
                    $display("FAIL f_latency: done at cycle %0d, expected %0d", cyc, e_f.cyc);
                end
            end
        end
    end

    // Bounded wait until every scoreboard is empty.
    task automatic drain();
        for (int i = 0; i < 200 && (q_m.size() + q_s.size() + q_f.size()) != 0; i++) begin
            @(negedge clk);
        end
        checks++;
        if ((q_m.size() + q_s.size() + q_f.size()) != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d results still pending, expected 0",
                     q_m.size() + q_s.size() + q_f.size());
            q_m.delete();
            q_s.delete();
            q_f.delete();
        end
        @(negedge clk);
    endtask

    // Call at a negedge; the following rising edge accepts.
    task automatic send_m(input logic [15:0] a, input logic [15:0] b, input logic c, input bit push);
        m_start = 1'b1;
        m_a     = a;
        m_b     = b;
        m_cin   = c;
        if (push) q_m.push_back(model16(a, b, c, 4));
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({m_busy, m_done, m_sum, m_cout, m_ovf} !== 20'd0) begin
            errors++;
            $display("FAIL reset_main: got busy=%b done=%b sum=%h cout=%b ovf=%b, expected all 0",
                     m_busy, m_done, m_sum, m_cout, m_ovf);
        end
        checks++;
        if ({s_busy, s_done, s_sum, s_cout, s_ovf} !== 8'd0) begin
            errors++;
            $display("FAIL reset_w4: got busy=%b done=%b sum=%h, expected all 0", s_busy, s_done, s_sum);
        end
        checks++;
        if ({f_busy, f_done, f_sum, f_cout, f_ovf} !== 20'd0) begin
            errors++;
            $display("FAIL reset_full: got busy=%b done=%b sum=%h, expected all 0", f_busy, f_done, f_sum);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({m_busy, m_done} !== 2'b00) begin
            errors++;
            $display("FAIL idle_after_reset: got busy=%b done=%b, expected 0 0", m_busy, m_done);
        end
    endtask

    task automatic test_corners();
        logic [15:0] va[3] = '{16'hFFFF, 16'h7FFF, 16'h8000};
        logic [15:0] vb[3] = '{16'h0001, 16'h0001, 16'h8000};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            send_m(va[i], vb[i], 1'b0, 1'b1);
            @(negedge clk);
            m_start = 1'b0;
            checks++;
            if (m_busy !== 1'b1) begin
                errors++;
                $display("FAIL busy_after_accept: got %b, expected 1", m_busy);
            end
            drain();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            send_m(16'($urandom), 16'($urandom), 1'($urandom), 1'b1);
            @(negedge clk);
            m_start = 1'b0;
            drain();
        end
    endtask

    // start held high: operands change every cycle, only the accepting-edge values count.
    task automatic test_start_held();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            send_m(16'($urandom), 16'($urandom), 1'($urandom), 1'b1);
            repeat (4) begin
                @(negedge clk);
                m_a   = 16'($urandom);
                m_b   = 16'($urandom);
                m_cin = 1'($urandom);
            end
        end
        @(negedge clk);
        m_start = 1'b0;
        drain();
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        send_m(16'h0001, 16'h0002, 1'b0, 1'b1);
        @(negedge clk);
        m_start = 1'b0;
        repeat (3) @(negedge clk);
        @(negedge clk);
        checks++;
        if ({m_done, m_busy} !== 2'b10) begin
            errors++;
            $display("FAIL b2b_done_cycle: got done=%b busy=%b, expected done=1 busy=0", m_done, m_busy);
        end
        send_m(16'h1234, 16'h4321, 1'b0, 1'b1);
        @(negedge clk);
        m_start = 1'b0;
        checks++;
        if ({m_done, m_busy} !== 2'b01) begin
            errors++;
            $display("FAIL b2b_busy_next: got done=%b busy=%b, expected done=0 busy=1", m_done, m_busy);
        end
        drain();
        checks++;
        if (m_sum !== 16'h5555) begin
            errors++;
            $display("FAIL b2b_sum: got %h, expected 5555", m_sum);
        end
    endtask

    task automatic test_reset_mid_op();
        @(negedge clk);
        send_m(16'h0F0F, 16'h0101, 1'b1, 1'b0);
        @(negedge clk);
        m_start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({m_busy, m_done, m_sum, m_cout, m_ovf} !== 20'd0) begin
            errors++;
            $display("FAIL reset_mid_op: got busy=%b done=%b sum=%h cout=%b ovf=%b, expected all 0",
                     m_busy, m_done, m_sum, m_cout, m_ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        @(negedge clk);
        send_m(16'hBEEF, 16'h1111, 1'b1, 1'b1);
        @(negedge clk);
        m_start = 1'b0;
        drain();
    endtask

    task automatic test_w4_exhaustive();
        for (int v = 0; v < 512; v++) begin
            logic [8:0] bits;
            bits = 9'(v);
            @(negedge clk);
            s_start = 1'b1;
            s_a     = bits[8:5];
            s_b     = bits[4:1];
            s_cin   = bits[0];
            q_s.push_back(model4(bits[8:5], bits[4:1], bits[0]));
            repeat (4) @(negedge clk);
        end
        @(negedge clk);
        s_start = 1'b0;
        drain();
    endtask

    task automatic test_full_digit();
        logic [15:0] va[3] = '{16'hAAAA, 16'h7FFF, 16'h1234};
        logic [15:0] vb[3] = '{16'h5555, 16'h0000, 16'hFEDC};
        logic        vc[3] = '{1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            f_start = 1'b1;
            f_a     = va[i];
            f_b     = vb[i];
            f_cin   = vc[i];
            q_f.push_back(model16(va[i], vb[i], vc[i], 1));
            @(negedge clk);
            f_start = 1'b0;
            drain();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        {m_start, m_a, m_b, m_cin} = '0;
        {s_start, s_a, s_b, s_cin} = '0;
        {f_start, f_a, f_b, f_cin} = '0;
        test_reset();
        test_corners();
        test_random();
        test_start_held();
        test_back_to_back();
        test_reset_mid_op();
        test_w4_exhaustive();
        test_full_digit();
        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
